// File: rtl/requant_pack_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// requant_pack_unit : LANES x int32 C word -> per-channel requantized int8 lanes
// packed into one response word.                                     Rev 1.0
// ----------------------------------------------------------------------------
module requant_pack_unit #(
   parameter int LANES       = 4,
   parameter int C_ADDR_BITS = 13,
   parameter int CH_BITS     = 9
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [1:0]             cfg_sel,
   input  logic [CH_BITS-1:0]     cfg_addr,
   input  logic [31:0]            cfg_data,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [C_ADDR_BITS-1:0] req_addr,
   input  logic [CH_BITS-1:0]     req_ch_base,
   output logic [C_ADDR_BITS-1:0] c_index,
   input  logic [32*LANES-1:0]    c_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [8*LANES-1:0]     out_data,
   output logic                   busy
);
   localparam int DEPTH = 2**CH_BITS;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      READ = 3'd1,
      MUL  = 3'd2,
      RND  = 3'd3,
      OUT  = 3'd4
   } state_t;

   state_t                state;
   logic [CH_BITS-1:0]    ch_base;
   logic signed [31:0]    offset;
   logic [31:0]           bias_mem  [DEPTH];
   logic [31:0]           mult_mem  [DEPTH];
   logic [4:0]            shift_mem [DEPTH];
   logic [8*LANES-1:0]    rnd_bytes;
   logic                  cfg_fire;

   assign req_ready = (state == IDLE);
   assign cfg_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign cfg_fire  = cfg_valid && cfg_ready;

   // Channel tables behave as RAM: contents survive reset.
   always_ff @(posedge clk) begin
      if (cfg_fire) begin
         case (cfg_sel)
            2'd0:    bias_mem[cfg_addr]  <= cfg_data;
            2'd1:    mult_mem[cfg_addr]  <= cfg_data;
            2'd2:    shift_mem[cfg_addr] <= cfg_data[4:0];
            default: ;
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [CH_BITS-1:0] ch;
         logic signed [31:0] acc, x, bias, mult;
         logic signed [63:0] prod_d, prod_q, nudged;
         logic signed [31:0] quot, h, q, y;
         logic [31:0]        mask, rem, thr;
         logic [4:0]         shamt;
         logic               sat_q;
         logic [7:0]         lane_byte;

         assign ch     = ch_base + CH_BITS'(gi);
         assign acc    = c_data[32*(LANES-gi)-1 -: 32];
         assign bias   = bias_mem[ch];
         assign mult   = mult_mem[ch];
         assign shamt  = shift_mem[ch];
         assign x      = acc + bias;
         assign prod_d = {{32{x[31]}}, x} * {{32{mult[31]}}, mult};

         always_ff @(posedge clk) begin
            if (state == MUL) begin
               prod_q <= prod_d;
               sat_q  <= (x == 32'sh8000_0000) && (mult == 32'sh8000_0000);
            end
         end

         // Divide by 2^31 truncating toward zero: floor, then bump negatives with a remainder.
         always_comb begin
            nudged = prod_q + (prod_q[63] ? -64'sd1073741823 : 64'sd1073741824);
            quot   = nudged[62:31];
            if (nudged[63] && (nudged[30:0] != '0))
               quot = quot + 32'sd1;
            h    = sat_q ? 32'sh7FFF_FFFF : quot;
            mask = (32'd1 << shamt) - 32'd1;
            rem  = h & mask;
            thr  = (mask >> 1) + {31'd0, h[31]};
            q    = (h >>> shamt) + ((rem > thr) ? 32'sd1 : 32'sd0);
            y    = q + offset;
            if (y < -32'sd128)
               lane_byte = 8'h80;
            else if (y > 32'sd127)
               lane_byte = 8'h7F;
            else
               lane_byte = y[7:0];
         end

         assign rnd_bytes[8*gi +: 8] = lane_byte;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         ch_base   <= '0;
         c_index   <= '0;
         offset    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (cfg_fire && (cfg_sel == 2'd3))
            offset <= cfg_data;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  ch_base <= req_ch_base;
                  c_index <= req_addr;
                  state   <= READ;
               end
            end
            READ: state <= MUL;
            MUL:  state <= RND;
            RND: begin
               out_data  <= rnd_bytes;
               out_valid <= 1'b1;
               state     <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_requant_pack_unit.sv
`default_nettype none
// tb_requant_pack_unit : vector table + scoreboard bench for requant_pack_unit.
module tb_requant_pack_unit;
   localparam int LANES = 4;
   localparam int CAB   = 13;
   localparam int CHB   = 9;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 cfg_valid = 1'b0, cfg_ready;
   logic [1:0]           cfg_sel = '0;
   logic [CHB-1:0]       cfg_addr = '0;
   logic [31:0]          cfg_data = '0;
   logic                 req_valid = 1'b0, req_ready;
   logic [CAB-1:0]       req_addr = '0;
   logic [CHB-1:0]       req_ch_base = '0;
   logic [CAB-1:0]       c_index;
   logic [32*LANES-1:0]  c_data = '0;
   logic                 out_valid, out_ready = 1'b0, busy;
   logic [8*LANES-1:0]   out_data;

   requant_pack_unit #(.LANES(LANES), .C_ADDR_BITS(CAB), .CH_BITS(CHB)) dut (
      .clk(clk), .reset(reset),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_ch_base(req_ch_base), .c_index(c_index), .c_data(c_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // C buffer model: registered read, data one cycle after c_index.
   logic [127:0] cmem [0:8191];
   always @(posedge clk) c_data <= cmem[c_index];

   // Reference copies of the tables.
   logic [31:0] bias_m  [512];
   logic [31:0] mult_m  [512];
   logic [4:0]  shift_m [512];
   logic [31:0] off_m = '0;

   logic [31:0] sb [$];
   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [8:0]        chb;
      logic [0:3][31:0]  bias;
      logic [31:0]       mult;
      logic [4:0]        shift;
      logic [31:0]       off;
      logic [0:3][31:0]  acc;
      logic [31:0]       exp;
   } vec_t;

   vec_t vt [6];

   function automatic vec_t mk(input logic [8:0] chb, input logic [127:0] bias,
                               input logic [31:0] mult, input logic [4:0] shift,
                               input logic [31:0] off, input logic [127:0] acc,
                               input logic [31:0] exp);
      vec_t v;
      v.chb = chb; v.bias = bias; v.mult = mult; v.shift = shift;
      v.off = off; v.acc = acc; v.exp = exp;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference requantizer; rounding written as half-away-from-zero on |h|.
   function automatic logic [7:0] rq(input logic [31:0] acc, input logic [31:0] b,
                                     input logic [31:0] m, input logic [4:0] s,
                                     input logic [31:0] off);
      int x, h, q, y;
      longint p, a;
      x = acc + b;
      if (x == int'(32'h8000_0000) && m == 32'h8000_0000) begin
         h = 32'h7FFF_FFFF;
      end else begin
         p = longint'(x) * longint'($signed(m));
         if (p >= 0) p = p + 64'sd1073741824;
         else        p = p - 64'sd1073741823;
         h = int'(p / 64'sd2147483648);
      end
      a = (h < 0) ? -longint'(h) : longint'(h);
      if (s != 5'd0) a = (a + (longint'(1) << (s - 5'd1))) >>> s;
      q = (h < 0) ? -int'(a) : int'(a);
      y = q + int'(off);
      if (y < -128) return 8'h80;
      if (y > 127)  return 8'h7F;
      return y[7:0];
   endfunction

   function automatic logic [31:0] model(input logic [12:0] addr, input logic [8:0] chb);
      logic [31:0]  w;
      logic [8:0]   ch;
      logic [127:0] word;
      word = cmem[addr];
      for (int i = 0; i < LANES; i++) begin
         ch = chb + 9'(i);
         w[8*i +: 8] = rq(word[127-32*i -: 32], bias_m[ch], mult_m[ch], shift_m[ch], off_m);
      end
      return w;
   endfunction

   task automatic cfg_write(input logic [1:0] sel, input logic [8:0] addr, input logic [31:0] data);
      @(negedge clk);
      cfg_valid = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_data = data;
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      case (sel)
         2'd0: bias_m[addr]  = data;
         2'd1: mult_m[addr]  = data;
         2'd2: shift_m[addr] = data[4:0];
         default: off_m = data;
      endcase
   endtask

   task automatic set_ch(input logic [8:0] ch, input logic [31:0] b, input logic [31:0] m,
                         input logic [4:0] s);
      cfg_write(2'd0, ch, b);
      cfg_write(2'd1, ch, m);
      cfg_write(2'd2, ch, {27'd0, s});
   endtask

   // One request; hold = cycles of out_ready low; poke = try a cfg write while stalled;
   // same_off = offset write presented on the same edge as the request.
   task automatic do_req(input logic [12:0] addr, input logic [8:0] chb, input logic [31:0] exp,
                         input int hold, input bit poke, input bit same_off,
                         input logic [31:0] off_val, input string name);
      int lat;
      logic [31:0] want;
      @(negedge clk);
      check({name, "/req_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_addr = addr; req_ch_base = chb;
      if (same_off) begin
         cfg_valid = 1'b1; cfg_sel = 2'd3; cfg_data = off_val;
      end
      sb.push_back(exp);
      @(posedge clk); #1;
      req_valid = 1'b0; cfg_valid = 1'b0;
      check({name, "/c_index"}, 32'(c_index), 32'(addr));
      check({name, "/busy"}, 32'(busy), 32'd1);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check({name, "/latency"}, 32'(lat), 32'd3);
      for (int k = 0; k < hold; k++) begin
         if (poke) begin
            cfg_valid = 1'b1; cfg_sel = 2'd3; cfg_data = 32'd77;
         end
         check({name, "/stall_valid"}, 32'(out_valid), 32'd1);
         check({name, "/stall_data"}, out_data, exp);
         check({name, "/stall_rdy"}, {30'd0, req_ready, cfg_ready}, 32'd0);
         @(posedge clk); #1;
      end
      cfg_valid = 1'b0;
      out_ready = 1'b1;
      check({name, "/out_valid"}, 32'(out_valid), 32'd1);
      want = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
      check({name, "/out_data"}, out_data, want);
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({name, "/done"}, {30'd0, out_valid, busy}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] e;
      logic [8:0]  chb;
      vt[0] = mk(9'd0,   {32'd0, 32'd0, 32'd0, 32'd0}, 32'h4000_0000, 5'd0, 32'd0,
                 {32'd10, -32'sd7, 32'd1000, -32'sd1000}, 32'h807F_FD05);
      vt[1] = mk(9'd4,   {32'd0, 32'd0, 32'd0, 32'd0}, 32'h4000_0000, 5'd1, -32'sd3,
                 {32'd100, -32'sd10, 32'd7, 32'd0}, 32'hFDFF_FA16);
      vt[2] = mk(9'd8,   {32'd0, 32'd0, 32'd0, 32'd0}, 32'h4000_0000, 5'd1, 32'd0,
                 {-32'sd10, -32'sd10, -32'sd10, -32'sd10}, 32'hFDFD_FDFD);
      vt[3] = mk(9'd12,  {32'd0, 32'd0, 32'd0, 32'd0}, 32'h7FFF_FFFF, 5'd31, 32'd5,
                 {32'h7FFF_FFFF, 32'd0, 32'h8000_0001, 32'h4000_0000}, 32'h0604_0506);
      vt[4] = mk(9'd16,  {32'd0, 32'd0, 32'd0, 32'd0}, 32'h8000_0000, 5'd0, 32'd0,
                 {32'h8000_0000, 32'h8000_0000, 32'd0, 32'h7FFF_FFFF}, 32'h8000_7F7F);
      vt[5] = mk(9'd511, {32'd90, -32'sd20, 32'd0, 32'd0}, 32'h4000_0000, 5'd0, 32'd0,
                 {32'd10, 32'd10, 32'd2, -32'sd2}, 32'hFF01_FB32);

      repeat (3) @(posedge clk);
      #1;
      check("reset/out_valid", 32'(out_valid), 32'd0);
      check("reset/busy", 32'(busy), 32'd0);
      check("reset/c_index", 32'(c_index), 32'd0);
      check("reset/out_data", out_data, 32'd0);
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      check("idle/ready", {30'd0, req_ready, cfg_ready}, 32'd3);

      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < LANES; i++)
            set_ch(vt[k].chb + 9'(i), vt[k].bias[i], vt[k].mult, vt[k].shift);
         cfg_write(2'd3, 9'd0, vt[k].off);
         cmem[13'(100 + k)] = vt[k].acc;
         do_req(13'(100 + k), vt[k].chb, vt[k].exp, 0, 1'b0, 1'b0, 32'd0, $sformatf("vec%0d", k));
      end

      // Backpressure with a refused cfg write during the stall.
      for (int i = 0; i < LANES; i++) set_ch(9'(20 + i), 32'd3, 32'h4000_0000, 5'd1);
      cfg_write(2'd3, 9'd0, 32'd3);
      cmem[300] = {32'd40, -32'sd41, 32'd9, 32'd500};
      e = model(13'd300, 9'd20);
      do_req(13'd300, 9'd20, e, 10, 1'b1, 1'b0, 32'd0, "stall");
      do_req(13'd300, 9'd20, e, 0, 1'b0, 1'b0, 32'd0, "post_stall");

      // Offset write on the same edge as the request.
      off_m = -32'sd9;
      e = model(13'd300, 9'd20);
      do_req(13'd300, 9'd20, e, 0, 1'b0, 1'b1, -32'sd9, "same_edge_cfg");

      // Reset while in RND, then a fresh request.
      for (int i = 0; i < LANES; i++) set_ch(9'(40 + i), 32'd0, 32'h4000_0000, 5'd2);
      cfg_write(2'd3, 9'd0, 32'd15);
      cmem[400] = {32'd40, -32'sd40, 32'd200, 32'd3};
      @(negedge clk);
      req_valid = 1'b1; req_addr = 13'd400; req_ch_base = 9'd40;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rnd/busy", 32'(busy), 32'd1);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("rst_mid/out_valid", 32'(out_valid), 32'd0);
      check("rst_mid/busy", 32'(busy), 32'd0);
      check("rst_mid/c_index", 32'(c_index), 32'd0);
      off_m = 32'd0;
      e = model(13'd400, 9'd40);
      do_req(13'd400, 9'd40, e, 0, 1'b0, 1'b0, 32'd0, "after_reset");

      // Random parameters and accumulators against the reference model.
      for (int r = 0; r < 6; r++) begin
         chb = 9'($urandom_range(0, 511));
         for (int i = 0; i < LANES; i++)
            set_ch(chb + 9'(i), 32'($urandom_range(0, 2000)) - 32'd1000, $urandom,
                   5'($urandom_range(0, 31)));
         cfg_write(2'd3, 9'd0, 32'($urandom_range(0, 40)) - 32'd20);
         cmem[13'(500 + r)] = {$urandom, $urandom, $urandom, $urandom};
         e = model(13'(500 + r), chb);
         do_req(13'(500 + r), chb, e, r % 3, 1'b0, 1'b0, 32'd0, $sformatf("rand%0d", r));
      end

      check("scoreboard/empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
